uart_tx_state_ctrl: RTL

UART_TX_STATE_CTRL -- requirements
Module: uart_tx_state_ctrl

---
 rtl/uart_tx_pkg.sv | 32 +++
 rtl/uart_tx_state_ctrl_clk_counter.sv | 39 +++
 rtl/uart_tx_state_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// UART transmit frame-state package: state encoding and state helpers.
// The parity state is always declared; UART_TX_PARITY_EN selects its use.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    s_IDLE          = 3'd0,
    s_TX_START_BIT  = 3'd1,
    s_TX_DATA_BITS  = 3'd2,
    s_TX_STOP_BIT   = 3'd3,
    s_CLEANUP       = 3'd4,
    s_TX_PARITY_BIT = 3'd5
  } state_t;

  localparam int CNT_W = 16;

  // States in which a bit is on the wire and the bit timer runs
  function automatic logic is_bit_state(input state_t s);
    logic busy;
    busy = 1'b0;
    case (s)
      s_TX_START_BIT,
      s_TX_DATA_BITS,
      s_TX_STOP_BIT: busy = 1'b1;
`ifdef UART_TX_PARITY_EN
      s_TX_PARITY_BIT: busy = 1'b1;
`endif
      default: busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/uart_tx_state_ctrl_clk_counter.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 while enabled.
// Clear has priority over enable; wraps to 0 after the last cycle.
module uart_tx_clk_counter
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_tx_state_ctrl.sv
// UART transmit frame controller: start, 8 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_state_ctrl
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_TX_DV,
  input  logic [7:0]  i_TX_Byte,
  input  logic [2:0]  bit_index,
  output state_t      current_state,
  output logic [15:0] clock_count,
  output logic        o_TX_Serial,
  output logic        o_TX_Active,
  output logic        o_TX_Done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] byte_q;
  logic [7:0] byte_d;
  logic       bit_end;
  logic       cnt_en;

`ifdef UART_TX_PARITY_EN
  logic parity_q;
  logic parity_d;
`endif

  assign cnt_en  = is_bit_state(state_q);
  assign bit_end = (clock_count == LAST);

  uart_tx_clk_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_clk_counter (
    .clk   (i_Clock),
    .rst   (i_Reset),
    .clear (!cnt_en),
    .enable(cnt_en),
    .count (clock_count)
  );

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      s_IDLE: begin
        if (i_TX_DV) begin
          byte_d  = i_TX_Byte;
`ifdef UART_TX_PARITY_EN
          parity_d = ^i_TX_Byte;
`endif
          state_d = s_TX_START_BIT;
        end
      end
      s_TX_START_BIT: begin
        if (bit_end) state_d = s_TX_DATA_BITS;
      end
      s_TX_DATA_BITS: begin
        if (bit_end && bit_index == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = s_TX_PARITY_BIT;
`else
          state_d = s_TX_STOP_BIT;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      s_TX_PARITY_BIT: begin
        if (bit_end) state_d = s_TX_STOP_BIT;
      end
`endif
      s_TX_STOP_BIT: begin
        if (bit_end) state_d = s_CLEANUP;
      end
      s_CLEANUP: state_d = s_IDLE;
      default:   state_d = s_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= s_IDLE;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    o_TX_Serial = 1'b1;
    case (state_q)
      s_TX_START_BIT:  o_TX_Serial = 1'b0;
      s_TX_DATA_BITS:  o_TX_Serial = byte_q[bit_index];
`ifdef UART_TX_PARITY_EN
      s_TX_PARITY_BIT: o_TX_Serial = parity_q;
`endif
      default:         o_TX_Serial = 1'b1;
    endcase
  end

  assign o_TX_Active   = cnt_en;
  assign o_TX_Done     = (state_q == s_CLEANUP);
  assign current_state = state_q;

endmodule
